mem_arbiter: RTL

Shares a single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. It sits between the pipeline and the external memory, serialises the two requesters with a small FSM, and handles variable memory wait states with a ready handshake. It returns registered results and drives one stall signal that freezes all pipeline registers until every active request in the current cycle has been served.

---
 rtl/mem_arbiter_pkg.sv | 10 +
 rtl/mem_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IF/MEM unified-memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } ArbState;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises IF and MEM stage requests onto one single-port memory and
// stalls the pipeline until every request of the current cycle is served.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_IReq,
    input  logic [ADDR_WIDTH-1:0] i_IAddr,
    output logic [DATA_WIDTH-1:0] o_IData,
    output logic                  o_IDone,
    input  logic                  i_DReq,
    input  logic                  i_DWrEnable,
    input  logic [ADDR_WIDTH-1:0] i_DAddr,
    input  logic [DATA_WIDTH-1:0] i_DWrData,
    output logic [DATA_WIDTH-1:0] o_DRdData,
    output logic                  o_DDone,
    output logic                  o_Stall,
    output logic                  o_MemReq,
    output logic [ADDR_WIDTH-1:0] o_MemAddr,
    output logic                  o_MemWrEnable,
    output logic [DATA_WIDTH-1:0] o_MemWrData,
    input  logic [DATA_WIDTH-1:0] i_MemRdData,
    input  logic                  i_MemReady
);

    ArbState               r_State;
    ArbState               w_NextState;
    logic                  r_IDone;
    logic                  r_DDone;
    logic                  r_WrEn;
    logic [ADDR_WIDTH-1:0] r_MemAddr;
    logic [DATA_WIDTH-1:0] r_MemWrData;
    logic [DATA_WIDTH-1:0] r_IData;
    logic [DATA_WIDTH-1:0] r_DRdData;

    logic w_IPend;
    logic w_DPend;
    logic w_Stall;
    logic w_IComplete;
    logic w_DComplete;

    assign w_IPend     = i_IReq & ~r_IDone;
    assign w_DPend     = i_DReq & ~r_DDone;
    assign w_Stall     = w_IPend | w_DPend;
    assign w_IComplete = (r_State == IACC) & i_MemReady;
    assign w_DComplete = (r_State == DACC) & i_MemReady;

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) r_State <= IDLE;
        else          r_State <= w_NextState;
    end

    // D wins in IDLE: it belongs to the older instruction in the pipe.
    always_comb begin
        w_NextState = r_State;
        case (r_State)
            IDLE: begin
                if (w_DPend)      w_NextState = DACC;
                else if (w_IPend) w_NextState = IACC;
            end
            IACC, DACC: begin
                if (i_MemReady) w_NextState = IDLE;
            end
            default: w_NextState = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_IDone     <= 1'b0;
            r_DDone     <= 1'b0;
            r_WrEn      <= 1'b0;
            r_MemAddr   <= '0;
            r_MemWrData <= '0;
            r_IData     <= '0;
            r_DRdData   <= '0;
        end else begin
            if (r_State == IDLE) begin
                if (w_DPend) begin
                    r_MemAddr   <= i_DAddr;
                    r_WrEn      <= i_DWrEnable;
                    r_MemWrData <= i_DWrData;
                end else if (w_IPend) begin
                    r_MemAddr <= i_IAddr;
                    r_WrEn    <= 1'b0;
                end
            end
            // Results land even if the requester has since dropped its request.
            if (w_IComplete)            r_IData   <= i_MemRdData;
            if (w_DComplete && !r_WrEn) r_DRdData <= i_MemRdData;
            if (!w_Stall) begin
                r_IDone <= 1'b0;
                r_DDone <= 1'b0;
            end else begin
                if (w_IComplete && i_IReq) r_IDone <= 1'b1;
                if (w_DComplete && i_DReq) r_DDone <= 1'b1;
            end
        end
    end

    assign o_Stall       = w_Stall;
    assign o_IDone       = r_IDone;
    assign o_DDone       = r_DDone;
    assign o_IData       = r_IData;
    assign o_DRdData     = r_DRdData;
    assign o_MemReq      = (r_State != IDLE);
    assign o_MemAddr     = r_MemAddr;
    assign o_MemWrEnable = (r_State == DACC) & r_WrEn;
    assign o_MemWrData   = r_MemWrData;

endmodule
